// File: rtl/sm_pkg.sv
// Shared types and helpers for the sign-magnitude adder arbiter.
// Used by the RTL and by the bench scoreboard.
package sm_pkg;

    localparam int SM_N = 4;

    typedef enum logic {
        IDLE = 1'b0,
        ADD  = 1'b1
    } state_t;

    // Magnitude overflow: signs match and the magnitude sum exceeds the (n-1)-bit range.
    // Operands are zero-extended to 32 bits by the caller; n is the real operand width.
    function automatic logic sm_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned n);
        logic [31:0] mask;
        logic [31:0] sa;
        logic [31:0] sb;
        mask = (32'd1 << (n - 1)) - 32'd1;
        sa   = (a >> (n - 1)) & 32'd1;
        sb   = (b >> (n - 1)) & 32'd1;
        return (sa == sb) && (((a & mask) + (b & mask)) > mask);
    endfunction

endpackage

// File: rtl/sign_mag_add.sv
// Purpose: combinational sign-magnitude add of two N-bit operands (MSB = sign).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller registers operands and result.
module sign_mag_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s
);

    localparam int M = N - 1;

    logic         sa;
    logic         sb;
    logic [M-1:0] ma;
    logic [M-1:0] mb;
    logic [M-1:0] mag_sum;
    logic [M-1:0] mag_ab;
    logic [M-1:0] mag_ba;

    assign sa      = a[N-1];
    assign sb      = b[N-1];
    assign ma      = a[M-1:0];
    assign mb      = b[M-1:0];
    assign mag_sum = ma + mb;
    assign mag_ab  = ma - mb;
    assign mag_ba  = mb - ma;

    // Equal magnitudes with differing signs fall to the last branch, so zero takes b's sign.
    always_comb begin
        s = '0;
        if (sa == sb) begin
            s = {sa, mag_sum};
        end else if (ma > mb) begin
            s = {sa, mag_ab};
        end else begin
            s = {sb, mag_ba};
        end
    end

endmodule

// File: rtl/sm_add_arbiter.sv
// Purpose: round-robin share of one sign-magnitude adder between two req/gnt requesters.
// Latency: grant on the sampling edge, registered sum/valid one edge later (1 op / 2 cycles).
// Backpressure: requests are level-held until granted; no requests sampled while adding.
module sm_add_arbiter
    import sm_pkg::*;
#(
    parameter int N = SM_N
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] sum,
    output logic         owner,
    output logic         ovf
);

    state_t       state;
    state_t       state_nxt;
    logic         last_served;
    logic         cur_owner;
    logic [N-1:0] a_r;
    logic [N-1:0] b_r;

    logic         any_req;
    logic         winner;
    logic         take;
    logic         gnt0_d;
    logic         gnt1_d;
    logic         busy_d;
    logic         valid_d;

    logic [N-1:0] add_sum;
    logic         add_ovf;

    assign any_req = req0 | req1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADD;
            ADD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/next-register logic; a tie goes to whoever was not served last.
    always_comb begin
        winner  = 1'b0;
        take    = 1'b0;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state)
            IDLE: begin
                winner = (req0 & req1) ? ~last_served : req1;
                take   = any_req;
                gnt0_d = any_req & ~winner;
                gnt1_d = any_req & winner;
                busy_d = any_req;
            end
            ADD: begin
                valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    sign_mag_add #(
        .N (N)
    ) u_add (
        .a (a_r),
        .b (b_r),
        .s (add_sum)
    );

    assign add_ovf = sm_ovf(32'(a_r), 32'(b_r), N);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            gnt0  <= gnt0_d;
            gnt1  <= gnt1_d;
            busy  <= busy_d;
            valid <= valid_d;
        end
    end

    // Operand capture and round-robin pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r         <= '0;
            b_r         <= '0;
            cur_owner   <= 1'b0;
            last_served <= 1'b1;
        end else if (take) begin
            a_r         <= winner ? a1 : a0;
            b_r         <= winner ? b1 : b0;
            cur_owner   <= winner;
            last_served <= winner;
        end
    end

    // Result registers hold until the next completed add
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum   <= '0;
            owner <= 1'b0;
            ovf   <= 1'b0;
        end else if (valid_d) begin
            sum   <= add_sum;
            owner <= cur_owner;
            ovf   <= add_ovf;
        end
    end

endmodule
